// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed 8-digit common-anode seven-segment scan controller
// Ports:
//   i_clk, i_rst_n          clock (rising edge) and synchronous active-low reset
//   i_wr_valid/o_wr_ready   host image handshake; one image can wait in the pending slot
//   i_wr_data/i_wr_dp/i_wr_en  per-digit nibble, decimal point and enable (digit 0 rightmost)
//   i_lz_blank              suppress leading zeros, sampled live
//   o_seg/o_dp/o_an         active-low segments {g..a}, decimal point and anodes
//   o_frame_done            one-cycle pulse on the last cycle of the last digit
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic [4*NUM_DIGITS-1:0] i_wr_data,
  input  logic [NUM_DIGITS-1:0]   i_wr_dp,
  input  logic [NUM_DIGITS-1:0]   i_wr_en,
  input  logic                    i_lz_blank,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_frame_done
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      default: dec = 7'h0E;
    endcase
  endfunction
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic                    r_pend_full;
  logic [4*NUM_DIGITS-1:0] r_pend_data, r_act_data;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_pend_en, r_act_dp, r_act_en;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp, r_fd;
  logic                    w_slot_end, w_last, w_accept, w_commit, w_on, w_zb;
  logic [4*NUM_DIGITS-1:0] w_data;
  logic [NUM_DIGITS-1:0]   w_dpv, w_env;
  logic [NUM_DIGITS:0]     w_nz;
  logic [3:0]              w_nib;
  assign o_wr_ready   = ~r_pend_full;
  assign o_an         = r_an;
  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_frame_done = r_fd;
  assign w_slot_end = r_cnt == CW'(TICK_DIV - 1);
  assign w_last     = w_slot_end && r_idx == IW'(NUM_DIGITS - 1);
  assign w_accept   = i_wr_valid && o_wr_ready;
  assign w_commit   = r_fd && r_pend_full;
  // The commit edge is also the edge that registers slot 0, so slot 0 must
  // already see the image being committed.
  assign w_data = w_commit ? r_pend_data : r_act_data;
  assign w_dpv  = w_commit ? r_pend_dp : r_act_dp;
  assign w_env  = w_commit ? r_pend_en : r_act_en;
  assign w_nib  = 4'(w_data >> {r_idx, 2'b00});
  // w_nz[i]: some nibble at position i or above is non-zero
  always_comb begin
    w_nz[NUM_DIGITS] = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) w_nz[i] = (|w_data[4*i +: 4]) | w_nz[i+1];
  end
  assign w_on = r_cnt >= CW'(BLANK_CYCLES) && w_env[r_idx];
  assign w_zb = i_lz_blank && r_idx != '0 && !w_nz[r_idx];
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_an  <= '1;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
      r_fd  <= 1'b0;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
      if (w_slot_end) r_idx <= w_last ? '0 : r_idx + 1'b1;
      r_an  <= w_on ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      r_seg <= (w_on && !w_zb) ? dec(w_nib) : 7'h7F;
      r_dp  <= w_on ? ~w_dpv[r_idx] : 1'b1;
      r_fd  <= w_last;
    end
  end
  // Accept and commit are exclusive: accept needs pending empty, commit needs it full.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pend_full <= 1'b0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend_en   <= '0;
      r_act_data  <= '0;
      r_act_dp    <= '0;
      r_act_en    <= '0;
    end else if (w_accept) begin
      r_pend_full <= 1'b1;
      r_pend_data <= i_wr_data;
      r_pend_dp   <= i_wr_dp;
      r_pend_en   <= i_wr_en;
    end else if (w_commit) begin
      r_pend_full <= 1'b0;
      r_act_data  <= r_pend_data;
      r_act_dp    <= r_pend_dp;
      r_act_en    <= r_pend_en;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized self-checking bench for seg7_scan_ctrl against a frame-position model
module tb_seg7_scan_ctrl;
  localparam int N = 8, TD = 8, BC = 2, FR = N * TD;
  logic        clk = 1'b0, rst_n, wr_valid, wr_ready, lz_blank, dp, frame_done;
  logic [31:0] wr_data;
  logic [7:0]  wr_dp, wr_en, an;
  logic [6:0]  seg;
  int n_chk = 0, n_fail = 0;
  int m_pos = 0;
  bit m_pend = 0;
  logic [31:0] m_pd = '0, m_ad = '0;
  logic [7:0]  m_pdp = '0, m_pen = '0, m_adp = '0, m_aen = '0;
  logic [7:0]  e_an = '1;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1, e_fd = 1'b0;
  logic [6:0]  lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  seg7_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_data(wr_data), .i_wr_dp(wr_dp), .i_wr_en(wr_en), .i_lz_blank(lz_blank),
    .o_seg(seg), .o_dp(dp), .o_an(an), .o_frame_done(frame_done));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  // Predict the effect of the coming rising edge from the inputs now driven,
  // then compare all outputs half a cycle later.
  task automatic cyc();
    logic [31:0] d;
    logic [7:0]  p, e;
    bit commit, on, zb;
    int c, g;
    if (!rst_n) begin
      m_pos = 0; m_pend = 0; m_ad = '0; m_adp = '0; m_aen = '0;
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      commit = e_fd && m_pend;
      d = commit ? m_pd : m_ad;
      p = commit ? m_pdp : m_adp;
      e = commit ? m_aen : m_aen;
      e = commit ? m_pen : m_aen;
      c = m_pos % TD;
      g = m_pos / TD;
      on = c >= BC && e[g];
      zb = lz_blank && g > 0 && (d >> (4 * g)) == 0;
      e_an  = on ? ~(8'd1 << g) : 8'hFF;
      e_seg = (on && !zb) ? lut[(d >> (4 * g)) & 32'hF] : 7'h7F;
      e_dp  = on ? ~p[g] : 1'b1;
      e_fd  = m_pos == FR - 1;
      if (wr_valid && !m_pend) begin
        m_pend = 1; m_pd = wr_data; m_pdp = wr_dp; m_pen = wr_en;
      end else if (commit) begin
        m_pend = 0; m_ad = m_pd; m_adp = m_pdp; m_aen = m_pen;
      end
      m_pos = (m_pos + 1) % FR;
    end
    @(negedge clk);
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
  endtask
  task automatic put(input logic [31:0] dat, input logic [7:0] dpv, input logic [7:0] env);
    bit done = 0;
    wr_valid = 1; wr_data = dat; wr_dp = dpv; wr_en = env;
    for (int i = 0; i < 3 * FR && !done; i++) begin
      done = !m_pend;
      cyc();
    end
    wr_valid = 0; wr_data = $urandom; wr_dp = 8'($urandom); wr_en = 8'($urandom);
    if (!done) chk("put_timeout", 0, 1);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  initial begin
    bit found;
    rst_n = 0; wr_valid = 0; wr_data = '0; wr_dp = '0; wr_en = '0; lz_blank = 0;
    run(2);
    rst_n = 1;
    run(3 * FR);
    put(32'h0123_89AF, 8'h04, 8'hFF);
    run(2 * FR);
    lz_blank = 1;
    put(32'h0000_0050, 8'h00, 8'hFF);
    run(2 * FR);
    put(32'h0000_0000, 8'h81, 8'hFF);
    run(2 * FR);
    lz_blank = 0;
    put(32'hFEDC_BA98, 8'h5A, 8'b1010_0101);
    run(2 * FR);
    put(32'h7654_3210, 8'hFF, 8'hFF);
    wr_valid = 1; wr_data = 32'hDEAD_BEEF; wr_en = 8'hFF; wr_dp = 8'h00;
    run(2 * FR);
    wr_valid = 0;
    run(FR);
    found = 0;
    for (int i = 0; i < 3 * FR && !found; i++) begin
      if (e_fd && !m_pend) found = 1; else cyc();
    end
    if (!found) chk("fd_wait", 0, 1);
    put(32'h1357_9BDF, 8'h0F, 8'hFF);
    run(3 * FR);
    put(32'h2468_ACE0, 8'hF0, 8'hFF);
    put(32'h1111_2222, 8'h00, 8'hFF);
    found = 0;
    for (int i = 0; i < 3 * FR && !found; i++) begin
      if (m_pos == 5 * TD + 3 && m_pend) found = 1; else cyc();
    end
    if (!found) chk("slot5_wait", 0, 1);
    rst_n = 0;
    cyc();
    rst_n = 1;
    run(2 * FR);
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom % 500) != 0;
      wr_valid = ($urandom % 8) == 0;
      wr_data = ($urandom % 3 == 0) ? ($urandom & 32'h0000_0FFF) : $urandom;
      wr_dp = 8'($urandom);
      wr_en = ($urandom % 2) ? 8'hFF : 8'($urandom);
      if ($urandom % 64 == 0) lz_blank = ~lz_blank;
      cyc();
    end
    rst_n = 1; wr_valid = 0;
    run(FR);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
